// File: rtl/ahb_lite_mem_tester_pkg.sv
// Shared AHB-Lite encodings, FSM states and pattern helpers for the memory tester.
// The LFSR pattern is selected with AHB_LITE_MEM_TESTER_LFSR_EN.
package ahb_lite_mem_tester_pkg;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HBURST_SINGLE = 3'b000;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [3:0]  HPROT_DATA    = 4'b0011;

    localparam logic [31:0] PATTERN_KEY   = 32'hA5A5_5A5A;
    localparam logic [31:0] LFSR_SEED     = 32'hACE1_0001;
    // Right-shift Galois form of x^32+x^22+x^2+x+1
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
    endfunction

    function automatic logic [31:0] addr_pattern(input logic [31:0] a);
        return a ^ PATTERN_KEY;
    endfunction

endpackage

// File: rtl/ahb_lite_mem_tester_if.sv
// AHB-Lite master/slave signal bundle used between the tester and a memory slave.
interface ahb_lite_mem_tester_if;
    logic [31:0] HADDR;
    logic [2:0]  HBURST;
    logic        HMASTLOCK;
    logic [3:0]  HPROT;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HADDR, HBURST, HMASTLOCK, HPROT, HSIZE, HTRANS, HWRITE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_pattern_gen.sv
// Test pattern source shared by the write and read passes: address-XOR by default,
// a Galois LFSR when AHB_LITE_MEM_TESTER_LFSR_EN is defined.
module ahb_lite_pattern_gen
    import ahb_lite_mem_tester_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          IDX_W     = 10
) (
`ifdef AHB_LITE_MEM_TESTER_LFSR_EN
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             restart_i,
    input  logic             step_i,
`else
    input  logic [IDX_W-1:0] index_i,
`endif
    output logic [31:0]      data_o
);

`ifdef AHB_LITE_MEM_TESTER_LFSR_EN
    logic [31:0] lfsr_q;

    // LFSR state: reseeded on restart (which wins over step), advanced on step
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (restart_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (step_i) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end else begin
            lfsr_q <= lfsr_q;
        end
    end

    assign data_o = lfsr_q;
`else
    assign data_o = addr_pattern(BASE_ADDR + (32'(index_i) << 2));
`endif

endmodule

// File: rtl/ahb_lite_mem_tester.sv
// AHB-Lite memory tester master: writes a pattern over WORDS words, reads it back and checks it.
// Pattern source selected by AHB_LITE_MEM_TESTER_LFSR_EN (undefined: address-XOR pattern).
module ahb_lite_mem_tester
    import ahb_lite_mem_tester_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          WORDS     = 1024,
    parameter int          ERR_W     = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 START,
    ahb_lite_mem_tester_if.master bus,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic                 BUS_ERR,
    output logic [ERR_W-1:0]     ERR_COUNT,
    output logic [31:0]          FIRST_ERR_ADDR
);

    localparam int              IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e           state_q;
    logic [31:0]      haddr_q;
    logic             htrans_q;
    logic             hwrite_q;
    logic [31:0]      hwdata_q;
    logic [IDX_W-1:0] addr_idx_q;
    logic [IDX_W-1:0] rd_idx_q;
    logic             dp_valid_q;
    logic             dp_write_q;
    logic [31:0]      dp_addr_q;
    logic             err_pend_q;
    logic             cmp_valid_q;
    logic             cmp_last_q;
    logic [31:0]      cmp_rdata_q;
    logic [31:0]      cmp_exp_q;
    logic [31:0]      cmp_addr_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic             bus_err_q;
    logic [ERR_W-1:0] err_cnt_q;
    logic [ERR_W-1:0] err_cnt_d;
    logic [31:0]      first_err_addr_q;
    logic [31:0]      first_err_addr_d;

    logic             accept_s;
    logic             sample_s;
    logic             mismatch_s;
    logic             start_ok_s;
    logic [31:0]      gen_data_s;

    assign start_ok_s = START && ((state_q == ST_IDLE) || (state_q == ST_FIN));
    assign accept_s   = bus.HREADY && htrans_q;
    // Read data is only trusted on a clean (OKAY) completion
    assign sample_s   = bus.HREADY && !bus.HRESP && dp_valid_q && !dp_write_q && !err_pend_q;
    assign mismatch_s = cmp_valid_q && (cmp_rdata_q != cmp_exp_q);

`ifdef AHB_LITE_MEM_TESTER_LFSR_EN
    logic gen_restart_s;
    logic gen_step_s;

    // LFSR control: seed at test start and again when the read pass begins
    always_comb begin
        gen_restart_s = start_ok_s ||
                        ((state_q == ST_WRITE) && accept_s && (addr_idx_q == LAST_IDX));
        gen_step_s    = ((state_q == ST_WRITE) && accept_s) || sample_s;
    end

    ahb_lite_pattern_gen #(
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_pattern_gen (
        .clk_i     (HCLK),
        .rst_n_i   (HRESETn),
        .restart_i (gen_restart_s),
        .step_i    (gen_step_s),
        .data_o    (gen_data_s)
    );
`else
    logic [IDX_W-1:0] gen_index_s;

    // Pattern index: address-phase word while writing, data-phase word while reading
    always_comb begin
        if (state_q == ST_WRITE) begin
            gen_index_s = addr_idx_q;
        end else begin
            gen_index_s = rd_idx_q;
        end
    end

    ahb_lite_pattern_gen #(
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (IDX_W)
    ) u_pattern_gen (
        .index_i   (gen_index_s),
        .data_o    (gen_data_s)
    );
`endif

    // Error bookkeeping for the registered compare stage
    always_comb begin
        err_cnt_d        = err_cnt_q;
        first_err_addr_d = first_err_addr_q;
        if (bus.HREADY && mismatch_s) begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (err_cnt_q == {ERR_W{1'b0}}) begin
                first_err_addr_d = cmp_addr_q;
            end else begin
                first_err_addr_d = first_err_addr_q;
            end
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Test sequencer and bus pipeline; everything but START and error handling waits on HREADY
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q          <= ST_IDLE;
            haddr_q          <= 32'h0000_0000;
            htrans_q         <= 1'b0;
            hwrite_q         <= 1'b0;
            hwdata_q         <= 32'h0000_0000;
            addr_idx_q       <= '0;
            rd_idx_q         <= '0;
            dp_valid_q       <= 1'b0;
            dp_write_q       <= 1'b0;
            dp_addr_q        <= 32'h0000_0000;
            err_pend_q       <= 1'b0;
            cmp_valid_q      <= 1'b0;
            cmp_last_q       <= 1'b0;
            cmp_rdata_q      <= 32'h0000_0000;
            cmp_exp_q        <= 32'h0000_0000;
            cmp_addr_q       <= 32'h0000_0000;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            bus_err_q        <= 1'b0;
            err_cnt_q        <= '0;
            first_err_addr_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE, ST_FIN: begin
                    if (START) begin
                        state_q          <= ST_WRITE;
                        haddr_q          <= BASE_ADDR;
                        htrans_q         <= 1'b1;
                        hwrite_q         <= 1'b1;
                        addr_idx_q       <= '0;
                        rd_idx_q         <= '0;
                        dp_valid_q       <= 1'b0;
                        err_pend_q       <= 1'b0;
                        cmp_valid_q      <= 1'b0;
                        busy_q           <= 1'b1;
                        done_q           <= 1'b0;
                        pass_q           <= 1'b0;
                        bus_err_q        <= 1'b0;
                        err_cnt_q        <= '0;
                        first_err_addr_q <= 32'h0000_0000;
                    end
                end
                ST_WRITE, ST_READ, ST_DRAIN: begin
                    err_cnt_q        <= err_cnt_d;
                    first_err_addr_q <= first_err_addr_d;
                    if (err_pend_q) begin
                        // Second ERROR cycle: abort the test, the failing transfer is dropped
                        if (bus.HREADY) begin
                            state_q     <= ST_FIN;
                            err_pend_q  <= 1'b0;
                            dp_valid_q  <= 1'b0;
                            cmp_valid_q <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            pass_q      <= 1'b0;
                            bus_err_q   <= 1'b1;
                        end
                    end else if (dp_valid_q && bus.HRESP && !bus.HREADY) begin
                        err_pend_q <= 1'b1;
                        htrans_q   <= 1'b0;
                    end else if (bus.HREADY) begin
                        dp_valid_q  <= htrans_q;
                        dp_write_q  <= hwrite_q;
                        dp_addr_q   <= haddr_q;
                        cmp_valid_q <= sample_s;
                        if (sample_s) begin
                            cmp_rdata_q <= bus.HRDATA;
                            cmp_exp_q   <= gen_data_s;
                            cmp_addr_q  <= dp_addr_q;
                            cmp_last_q  <= (rd_idx_q == LAST_IDX);
                            rd_idx_q    <= rd_idx_q + IDX_W'(1);
                        end
                        if (state_q == ST_WRITE && accept_s) begin
                            hwdata_q <= gen_data_s;
                            if (addr_idx_q == LAST_IDX) begin
                                state_q    <= ST_READ;
                                haddr_q    <= BASE_ADDR;
                                hwrite_q   <= 1'b0;
                                addr_idx_q <= '0;
                            end else begin
                                haddr_q    <= haddr_q + 32'd4;
                                addr_idx_q <= addr_idx_q + IDX_W'(1);
                            end
                        end else if (state_q == ST_READ && accept_s) begin
                            if (addr_idx_q == LAST_IDX) begin
                                state_q  <= ST_DRAIN;
                                htrans_q <= 1'b0;
                            end else begin
                                haddr_q    <= haddr_q + 32'd4;
                                addr_idx_q <= addr_idx_q + IDX_W'(1);
                            end
                        end else if (state_q == ST_DRAIN && cmp_valid_q && cmp_last_q) begin
                            state_q <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_cnt_d == {ERR_W{1'b0}}) && !bus_err_q;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    htrans_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HADDR      = haddr_q;
    assign bus.HBURST     = HBURST_SINGLE;
    assign bus.HMASTLOCK  = 1'b0;
    assign bus.HPROT      = HPROT_DATA;
    assign bus.HSIZE      = HSIZE_WORD;
    assign bus.HTRANS     = htrans_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign bus.HWRITE     = hwrite_q;
    assign bus.HWDATA     = hwdata_q;

    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign PASS           = pass_q;
    assign BUS_ERR        = bus_err_q;
    assign ERR_COUNT      = err_cnt_q;
    assign FIRST_ERR_ADDR = first_err_addr_q;

endmodule

// File: tb/tb_ahb_lite_mem_tester.sv
// Directed bench for ahb_lite_mem_tester: behavioural RAM slave with wait/error/corrupt knobs
// and a scoreboard of expected address phases and write data.
module tb_ahb_lite_mem_tester;

`ifdef AHB_LITE_MEM_TESTER_LFSR_EN
    localparam int W = 3;
`else
    localparam int W = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass, bus_err;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    ahb_lite_mem_tester_if bus ();

    ahb_lite_mem_tester #(
        .BASE_ADDR (32'h0000_0000),
        .WORDS     (W),
        .ERR_W     (16)
    ) dut (
        .HCLK           (clk),
        .HRESETn        (rst_n),
        .START          (start),
        .bus            (bus),
        .BUSY           (busy),
        .DONE           (done),
        .PASS           (pass),
        .BUS_ERR        (bus_err),
        .ERR_COUNT      (err_count),
        .FIRST_ERR_ADDR (first_err_addr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
    } xfer_t;
    xfer_t       aq[$];
    logic [31:0] dq[$];

    // slave configuration
    int          wait_n = 0;
    logic        err_en = 1'b0;
    logic        corrupt_en = 1'b0;
    logic        stab_en = 1'b0;

    // slave state
    logic [31:0] mem [0:15];
    logic        s_dp_v = 1'b0;
    logic        s_dp_w = 1'b0;
    logic [31:0] s_dp_a = 32'h0;
    int          s_wcnt = 0;
    logic        s_err;
    logic        s_ready, s_resp;
    logic [31:0] s_rdata;

    always @(posedge clk) begin
        if (!rst_n) begin
            s_dp_v <= 1'b0;
            s_wcnt <= 0;
        end else if (s_ready) begin
            if (s_dp_v && s_dp_w && !s_resp) mem[s_dp_a[5:2]] <= bus.HWDATA;
            s_dp_v <= (bus.HTRANS == 2'b10);
            s_dp_w <= bus.HWRITE;
            s_dp_a <= bus.HADDR;
            s_wcnt <= 0;
        end else begin
            s_wcnt <= s_wcnt + 1;
        end
    end

    always_comb begin
        s_err   = s_dp_v && err_en && s_dp_w && (s_dp_a == 32'h4);
        s_ready = 1'b1;
        s_resp  = 1'b0;
        s_rdata = 32'h0;
        if (s_err) begin
            s_ready = (s_wcnt >= 1);
            s_resp  = 1'b1;
        end else if (s_dp_v) begin
            s_ready = (s_wcnt >= wait_n);
        end
        if (s_dp_v && !s_dp_w)
            s_rdata = mem[s_dp_a[5:2]] ^ ((corrupt_en && s_dp_a == 32'h8) ? 32'h1 : 32'h0);
    end

    assign bus.HREADY = s_ready;
    assign bus.HRESP  = s_resp;
    assign bus.HRDATA = s_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        logic [31:0] s;
`ifdef AHB_LITE_MEM_TESTER_LFSR_EN
        s = 32'hACE1_0001;
        for (int k = 0; k < i; k++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
`else
        s = (32'(i) * 32'd4) ^ 32'hA5A5_5A5A;
`endif
        return s;
    endfunction

    task automatic push_exp(input int nwr, input int nwd, input int nrd);
        xfer_t x;
        for (int i = 0; i < nwr; i++) begin x.addr = 32'(i) * 32'd4; x.wr = 1'b1; aq.push_back(x); end
        for (int i = 0; i < nwd; i++) dq.push_back(pat(i));
        for (int i = 0; i < nrd; i++) begin x.addr = 32'(i) * 32'd4; x.wr = 1'b0; aq.push_back(x); end
    endtask

    // Scoreboard monitor, sampling on the falling edge
    logic        stall_prev = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic [1:0]  snap_trans;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.HTRANS == 2'b10 && bus.HREADY) begin
                if (aq.size() == 0) begin
                    n_chk++; n_fail++;
                    $error("FAIL unexpected_xfer: observed addr %0h expected none", bus.HADDR);
                end else begin
                    xfer_t x;
                    x = aq.pop_front();
                    check("haddr", bus.HADDR, x.addr);
                    check("hwrite", 32'(bus.HWRITE), 32'(x.wr));
                end
            end
            if (s_dp_v && s_dp_w && bus.HREADY && !bus.HRESP) begin
                if (dq.size() == 0) begin
                    n_chk++; n_fail++;
                    $error("FAIL unexpected_wdata: observed %0h expected none", bus.HWDATA);
                end else begin
                    check("hwdata", bus.HWDATA, dq.pop_front());
                end
            end
            if (s_err && s_wcnt == 1) check("htrans_err2", 32'(bus.HTRANS), 32'h0);
            if (stab_en && stall_prev) begin
                check("stall_haddr", bus.HADDR, snap_addr);
                check("stall_htrans", 32'(bus.HTRANS), 32'(snap_trans));
                check("stall_hwdata", bus.HWDATA, snap_wdata);
            end
            stall_prev = !bus.HREADY;
            snap_addr  = bus.HADDR;
            snap_trans = bus.HTRANS;
            snap_wdata = bus.HWDATA;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_htrans"}, 32'(bus.HTRANS), 32'h0);
        check({tag, "_hwrite"}, 32'(bus.HWRITE), 32'h0);
        check({tag, "_haddr"}, bus.HADDR, 32'h0);
        check({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_done"}, 32'(done), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'h0);
        check({tag, "_buserr"}, 32'(bus_err), 32'h0);
        check({tag, "_errcnt"}, 32'(err_count), 32'h0);
        check({tag, "_firsterr"}, first_err_addr, 32'h0);
    endtask

    task automatic run_test(input string tag, input int exp_edge, input int busy_k,
                            input logic exp_pass, input logic exp_berr,
                            input int exp_cnt, input logic [31:0] exp_first);
        int k;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'h1);
        check({tag, "_done_clr"}, 32'(done), 32'h0);
        k = 0;
        while (k < 300 && !done) begin
            if (k == busy_k) start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            k++;
        end
        check({tag, "_done_edge"}, 32'(k), 32'(exp_edge));
        check({tag, "_busy_end"}, 32'(busy), 32'h0);
        check({tag, "_pass"}, 32'(pass), 32'(exp_pass));
        check({tag, "_buserr"}, 32'(bus_err), 32'(exp_berr));
        check({tag, "_errcnt"}, 32'(err_count), 32'(exp_cnt));
        check({tag, "_firsterr"}, first_err_addr, exp_first);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_aq_empty"}, 32'(aq.size()), 32'h0);
        check({tag, "_dq_empty"}, 32'(dq.size()), 32'h0);
    endtask

    initial begin
        int k;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;

        // 1: zero-wait, ideal slave, START while busy ignored
        push_exp(W, W, W);
        check("pat0", pat(0), W == 3 ? 32'hACE1_0001 : 32'hA5A5_5A5A);
        run_test("t1", 2 * W + 2, 3, 1'b1, 1'b0, 0, 32'h0);

        // 2: two wait states per transfer, outputs stable while stalled
        wait_n = 2; stab_en = 1'b1;
        push_exp(W, W, W);
        run_test("t2", 2 * W + 2 + 4 * W, -1, 1'b1, 1'b0, 0, 32'h0);
        wait_n = 0; stab_en = 1'b0;

        // 3: bit 0 of word at address 8 corrupted on read
        corrupt_en = 1'b1;
        push_exp(W, W, W);
        run_test("t3", 2 * W + 2, -1, 1'b0, 1'b0, 1, 32'h8);
        corrupt_en = 1'b0;

        // 4: ERROR response on write of address 4, no reads may follow
        err_en = 1'b1;
        push_exp(2, 1, 0);
        run_test("t4", 4, -1, 1'b0, 1'b1, 0, 32'h0);
        err_en = 1'b0;

        // 5: reset in the middle of the read pass, then a fresh test
        push_exp(W, W, W);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (k < 50 && bus.HWRITE !== 1'b0) begin
            @(posedge clk); #1;
            k++;
        end
        check("t5_reached_read", 32'(bus.HWRITE), 32'h0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset("t5_rst");
        rst_n = 1'b1;
        aq.delete();
        dq.delete();
        push_exp(W, W, W);
        run_test("t5_fresh", 2 * W + 2, 2, 1'b1, 1'b0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
